// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the ID-stage hazard stall unit.
// Control vectors order: {PCWrite, IF_ID_Write, ID_EX_Flush, pipe_hold}.
package hazard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STALL      = 2'd1,
        MEM_WAIT   = 2'd2,
        MEM_WAIT_S = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_flush;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_PASS   = 4'b1100;
    localparam ctrl_t CTRL_STALL  = 4'b0010;
    localparam ctrl_t CTRL_FREEZE = 4'b0001;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard stall unit.
// Optional statistics outputs are present when HAZARD_STATS_EN is defined.
interface hazard_stall_unit_if #(parameter int REG_W = 5);
    logic [REG_W-1:0] IF_ID_rs;
    logic [REG_W-1:0] IF_ID_rt;
    logic             IF_ID_use_rt;
    logic             IF_ID_branch;
    logic [REG_W-1:0] ID_EX_rt;
    logic [REG_W-1:0] ID_EX_regres;
    logic             ID_EX_RegWrite;
    logic             ID_EX_MEMRead;
    logic [REG_W-1:0] EX_MEM_regres;
    logic             EX_MEM_MEMRead;
    logic             mem_req;
    logic             mem_ready;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             ID_EX_Flush;
    logic             pipe_hold;
`ifdef HAZARD_STATS_EN
    logic [31:0]      lu_stalls;
    logic [31:0]      br_stalls;
    logic [31:0]      mem_freezes;
`endif

    modport master (
        output IF_ID_rs, output IF_ID_rt, output IF_ID_use_rt, output IF_ID_branch,
        output ID_EX_rt, output ID_EX_regres, output ID_EX_RegWrite, output ID_EX_MEMRead,
        output EX_MEM_regres, output EX_MEM_MEMRead, output mem_req, output mem_ready,
        input PCWrite, input IF_ID_Write, input ID_EX_Flush, input pipe_hold
`ifdef HAZARD_STATS_EN
        , input lu_stalls, input br_stalls, input mem_freezes
`endif
    );

    modport slave (
        input IF_ID_rs, input IF_ID_rt, input IF_ID_use_rt, input IF_ID_branch,
        input ID_EX_rt, input ID_EX_regres, input ID_EX_RegWrite, input ID_EX_MEMRead,
        input EX_MEM_regres, input EX_MEM_MEMRead, input mem_req, input mem_ready,
        output PCWrite, output IF_ID_Write, output ID_EX_Flush, output pipe_hold
`ifdef HAZARD_STATS_EN
        , output lu_stalls, output br_stalls, output mem_freezes
`endif
    );
endinterface

// File: rtl/hazard_stall_unit_match.sv
// Source-operand match: d is a hazard if it is nonzero and equals rs,
// or equals rt when the ID instruction actually reads rt.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] d,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rt,
    output logic             hit
);
    assign hit = (d != REG_W'(REG_ZERO)) && ((d == rs) || (use_rt && (d == rt)));
endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/freeze controller for hazards forwarding cannot cover.
// Define HAZARD_STATS_EN to add saturating stall/freeze statistics counters.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_unit_if.slave bus
);

    logic             hit_ld_s;
    logic             hit_ex_s;
    logic             hit_mem_s;
    logic             lu_s;
    logic             br1_s;
    logic             br2_s;
    logic             mw_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    ctrl_t            ctrl_s;
    ctrl_t            ctrl_out_s;

    hazard_match #(.REG_W(REG_W)) u_match_ld (
        .d(bus.ID_EX_rt), .rs(bus.IF_ID_rs), .rt(bus.IF_ID_rt),
        .use_rt(bus.IF_ID_use_rt), .hit(hit_ld_s)
    );
    hazard_match #(.REG_W(REG_W)) u_match_ex (
        .d(bus.ID_EX_regres), .rs(bus.IF_ID_rs), .rt(bus.IF_ID_rt),
        .use_rt(bus.IF_ID_use_rt), .hit(hit_ex_s)
    );
    hazard_match #(.REG_W(REG_W)) u_match_mem (
        .d(bus.EX_MEM_regres), .rs(bus.IF_ID_rs), .rt(bus.IF_ID_rt),
        .use_rt(bus.IF_ID_use_rt), .hit(hit_mem_s)
    );

    assign lu_s  = bus.ID_EX_MEMRead && hit_ld_s;
    assign br2_s = bus.IF_ID_branch && lu_s;
    assign br1_s = bus.IF_ID_branch &&
                   ((bus.ID_EX_RegWrite && !bus.ID_EX_MEMRead && hit_ex_s) ||
                    (bus.EX_MEM_MEMRead && hit_mem_s));
    assign mw_s  = bus.mem_req && !bus.mem_ready;

    // Next-state, stall-count and Mealy control decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ctrl_s      = CTRL_PASS;
        case (state_r)
            RUN, MEM_WAIT: begin
                // A wait state releasing on mem_ready decodes exactly like RUN
                if (mw_s || ((state_r == MEM_WAIT) && !bus.mem_ready)) begin
                    ctrl_s      = CTRL_FREEZE;
                    state_nxt_s = MEM_WAIT;
                end else if (br2_s) begin
                    ctrl_s      = CTRL_STALL;
                    cnt_nxt_s   = CNT_W'(1'b1);
                    state_nxt_s = STALL;
                end else if (br1_s || lu_s) begin
                    ctrl_s      = CTRL_STALL;
                    state_nxt_s = RUN;
                end else begin
                    ctrl_s      = CTRL_PASS;
                    state_nxt_s = RUN;
                end
            end
            STALL, MEM_WAIT_S: begin
                if (mw_s || ((state_r == MEM_WAIT_S) && !bus.mem_ready)) begin
                    ctrl_s      = CTRL_FREEZE;
                    state_nxt_s = MEM_WAIT_S;
                end else begin
                    ctrl_s = CTRL_STALL;
                    if (cnt_r != '0) begin
                        cnt_nxt_s = cnt_r - CNT_W'(1'b1);
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                    if (cnt_r <= CNT_W'(1'b1)) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = STALL;
                    end
                end
            end
            default: begin
                ctrl_s      = CTRL_STALL;
                cnt_nxt_s   = '0;
                state_nxt_s = RUN;
            end
        endcase
    end

    // Reset forces the bubble/no-fetch pattern regardless of state
    always_comb begin
        if (!rst_n) begin
            ctrl_out_s = CTRL_STALL;
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign bus.PCWrite     = ctrl_out_s.pc_write;
    assign bus.IF_ID_Write = ctrl_out_s.if_id_write;
    assign bus.ID_EX_Flush = ctrl_out_s.id_ex_flush;
    assign bus.pipe_hold   = ctrl_out_s.pipe_hold;

    // State and branch-stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef HAZARD_STATS_EN
    logic        stall_cyc_s;
    logic        br_cyc_s;
    logic        freeze_cyc_s;
    logic [31:0] lu_cnt_r;
    logic [31:0] br_cnt_r;
    logic [31:0] fr_cnt_r;

    // A stall is a branch stall if any branch condition or the STALL path caused it
    assign stall_cyc_s  = (ctrl_s == CTRL_STALL);
    assign freeze_cyc_s = (ctrl_s == CTRL_FREEZE);
    assign br_cyc_s     = stall_cyc_s && (br1_s || br2_s ||
                          (state_r == STALL) || (state_r == MEM_WAIT_S));

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_r <= 32'd0;
            br_cnt_r <= 32'd0;
            fr_cnt_r <= 32'd0;
        end else begin
            if (stall_cyc_s && !br_cyc_s) begin
                lu_cnt_r <= sat_inc(lu_cnt_r);
            end else begin
                lu_cnt_r <= lu_cnt_r;
            end
            if (br_cyc_s) begin
                br_cnt_r <= sat_inc(br_cnt_r);
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (freeze_cyc_s) begin
                fr_cnt_r <= sat_inc(fr_cnt_r);
            end else begin
                fr_cnt_r <= fr_cnt_r;
            end
        end
    end

    assign bus.lu_stalls   = lu_cnt_r;
    assign bus.br_stalls   = br_cnt_r;
    assign bus.mem_freezes = fr_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus random
// traffic against a cycle-count reference model.
module tb_hazard_stall_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   fails = 0;

    // Reference model: wait flag, remaining branch-stall cycles, stat counts
    bit     m_wait;
    int     m_left;
    longint m_lu, m_br, m_fr;

    localparam logic [3:0] E_PASS   = 4'b1100;
    localparam logic [3:0] E_STALL  = 4'b0010;
    localparam logic [3:0] E_FREEZE = 4'b0001;

    hazard_stall_unit_if #(.REG_W(5)) hif();

    hazard_stall_unit #(.REG_W(5), .CNT_W(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(hif)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {hif.PCWrite, hif.IF_ID_Write, hif.ID_EX_Flush, hif.pipe_hold};
    endfunction

    function automatic bit hit(logic [4:0] d);
        return (d != 5'd0) && ((d == hif.IF_ID_rs) || (hif.IF_ID_use_rt && (d == hif.IF_ID_rt)));
    endfunction

    task automatic model_reset();
        m_wait = 1'b0;
        m_left = 0;
        m_lu = 0;
        m_br = 0;
        m_fr = 0;
    endtask

    // Expected outputs for this cycle's inputs; advances the model one cycle
    task automatic model_step(output logic [3:0] e);
        bit lu, br1, br2, mw;
        lu  = hif.ID_EX_MEMRead && hit(hif.ID_EX_rt);
        br2 = hif.IF_ID_branch && lu;
        br1 = hif.IF_ID_branch &&
              ((hif.ID_EX_RegWrite && !hif.ID_EX_MEMRead && hit(hif.ID_EX_regres)) ||
               (hif.EX_MEM_MEMRead && hit(hif.EX_MEM_regres)));
        mw  = hif.mem_req && !hif.mem_ready;
        if (mw || (m_wait && !hif.mem_ready)) begin
            e = E_FREEZE;
            m_wait = 1'b1;
            m_fr++;
        end else begin
            m_wait = 1'b0;
            if (m_left > 0) begin
                e = E_STALL; m_left--; m_br++;
            end else if (br2) begin
                e = E_STALL; m_left = 1; m_br++;
            end else if (br1) begin
                e = E_STALL; m_br++;
            end else if (lu) begin
                e = E_STALL; m_lu++;
            end else begin
                e = E_PASS;
            end
        end
    endtask

    task automatic set_idle();
        hif.IF_ID_rs = 5'd0;       hif.IF_ID_rt = 5'd0;
        hif.IF_ID_use_rt = 1'b0;   hif.IF_ID_branch = 1'b0;
        hif.ID_EX_rt = 5'd0;       hif.ID_EX_regres = 5'd0;
        hif.ID_EX_RegWrite = 1'b0; hif.ID_EX_MEMRead = 1'b0;
        hif.EX_MEM_regres = 5'd0;  hif.EX_MEM_MEMRead = 1'b0;
        hif.mem_req = 1'b0;        hif.mem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        #2;
        checks++;
        if (outs() !== E_STALL) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b", outs(), E_STALL);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if ({hif.lu_stalls, hif.br_stalls, hif.mem_freezes} !== 96'd0) begin
            fails++;
            $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0",
                     hif.lu_stalls, hif.br_stalls, hif.mem_freezes);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [3:0] e;
        set_idle();
        hif.ID_EX_MEMRead = 1'b1; hif.ID_EX_rt = 5'd8; hif.IF_ID_rs = 5'd8;
        for (int c = 0; c < 2; c++) begin
            if (c == 1) hif.ID_EX_MEMRead = 1'b0;
            @(negedge clk);
            model_step(e);
            checks++;
            if (outs() !== e) begin
                fails++;
                $display("FAIL load_use c%0d: got %b expected %b", c, outs(), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_reg_zero();
        logic [3:0] e;
        set_idle();
        hif.ID_EX_MEMRead = 1'b1; hif.ID_EX_rt = 5'd0; hif.IF_ID_rs = 5'd0;
        hif.IF_ID_branch = 1'b1;
        @(negedge clk);
        model_step(e);
        checks++;
        if (outs() !== e) begin
            fails++;
            $display("FAIL reg_zero: got %b expected %b", outs(), e);
        end
        next_cycle();
    endtask

    task automatic test_load_branch();
        logic [3:0] e;
        set_idle();
        hif.IF_ID_branch = 1'b1; hif.ID_EX_MEMRead = 1'b1; hif.ID_EX_rt = 5'd9;
        hif.IF_ID_rt = 5'd9; hif.IF_ID_use_rt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            // ID_EX becomes a bubble after the first stall cycle
            if (c == 1) begin hif.ID_EX_MEMRead = 1'b0; hif.ID_EX_rt = 5'd0; end
            if (c == 2) hif.IF_ID_branch = 1'b0;
            @(negedge clk);
            model_step(e);
            checks++;
            if (outs() !== e) begin
                fails++;
                $display("FAIL load_branch c%0d: got %b expected %b", c, outs(), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        logic [3:0] e;
        set_idle();
        hif.mem_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            hif.mem_ready = (c == 3);
            if (c == 4) hif.mem_req = 1'b0;
            @(negedge clk);
            model_step(e);
            checks++;
            if (outs() !== e) begin
                fails++;
                $display("FAIL mem_wait c%0d: got %b expected %b", c, outs(), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_wait_in_stall();
        logic [3:0] e;
        set_idle();
        hif.IF_ID_branch = 1'b1; hif.ID_EX_MEMRead = 1'b1; hif.ID_EX_rt = 5'd5;
        hif.IF_ID_rs = 5'd5;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin
                hif.ID_EX_MEMRead = 1'b0; hif.ID_EX_rt = 5'd0;
                hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
            end
            if (c == 3) hif.mem_ready = 1'b1;
            if (c == 4) begin hif.mem_req = 1'b0; hif.mem_ready = 1'b0; end
            if (c == 5) hif.IF_ID_branch = 1'b0;
            @(negedge clk);
            model_step(e);
            checks++;
            if (outs() !== e) begin
                fails++;
                $display("FAIL wait_in_stall c%0d: got %b expected %b", c, outs(), e);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [3:0] e;
        for (int c = 0; c < 400; c++) begin
            hif.IF_ID_rs       = 5'($urandom_range(0, 3));
            hif.IF_ID_rt       = 5'($urandom_range(0, 3));
            hif.IF_ID_use_rt   = 1'($urandom_range(0, 1));
            hif.IF_ID_branch   = 1'($urandom_range(0, 1));
            hif.ID_EX_rt       = 5'($urandom_range(0, 3));
            hif.ID_EX_regres   = 5'($urandom_range(0, 3));
            hif.ID_EX_RegWrite = 1'($urandom_range(0, 1));
            hif.ID_EX_MEMRead  = ($urandom_range(0, 2) == 0);
            hif.EX_MEM_regres  = 5'($urandom_range(0, 3));
            hif.EX_MEM_MEMRead = 1'($urandom_range(0, 1));
            hif.mem_req        = ($urandom_range(0, 3) == 0);
            hif.mem_ready      = 1'($urandom_range(0, 1));
            @(negedge clk);
            model_step(e);
            checks++;
            if (outs() !== e) begin
                fails++;
                $display("FAIL random c%0d: got %b expected %b", c, outs(), e);
            end
            next_cycle();
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if ({hif.lu_stalls, hif.br_stalls, hif.mem_freezes} !==
            {32'(m_lu), 32'(m_br), 32'(m_fr)}) begin
            fails++;
            $display("FAIL stats: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     hif.lu_stalls, hif.br_stalls, hif.mem_freezes, m_lu, m_br, m_fr);
        end
`endif
    endtask

    task automatic test_mid_reset();
        logic [3:0] e;
        set_idle();
        hif.IF_ID_branch = 1'b1; hif.ID_EX_MEMRead = 1'b1; hif.ID_EX_rt = 5'd7;
        hif.IF_ID_rs = 5'd7;
        @(negedge clk);
        model_step(e);
        checks++;
        if (outs() !== e) begin
            fails++;
            $display("FAIL mid_reset_entry: got %b expected %b", outs(), e);
        end
        next_cycle();
        // DUT now sits in STALL with one stall cycle left
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== E_STALL) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %b expected %b", outs(), E_STALL);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if ({hif.lu_stalls, hif.br_stalls, hif.mem_freezes} !== 96'd0) begin
            fails++;
            $display("FAIL mid_reset_stats: got %0d/%0d/%0d expected 0/0/0",
                     hif.lu_stalls, hif.br_stalls, hif.mem_freezes);
        end
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        model_step(e);
        checks++;
        if (outs() !== e) begin
            fails++;
            $display("FAIL mid_reset_resume: got %b expected %b", outs(), e);
        end
        next_cycle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_reg_zero();
        test_load_branch();
        test_mem_wait();
        test_wait_in_stall();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
